// File: rtl/idu_pkg.sv
// Shared IDU definitions: exception bit positions and the dispatch FSM state.
package idu_pkg;

    localparam int EXC_PC_UNALIGN = 0;
    localparam int EXC_ILLEGAL    = 1;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } disp_state_e;

endpackage

// File: rtl/u_idu_load_scoreboard.sv
// Load-use scoreboard: one countdown per architectural register (x0 never tracked).
// A freshly dispatched load reloads LOAD_LAT; otherwise nonzero counters tick down.
module u_idu_load_scoreboard #(
    parameter int ISSUE_W      = 2,
    parameter int RF_DEPTH_BIT = 5,
    parameter int LOAD_LAT     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ISSUE_W-1:0]                set_en,
    input  logic [ISSUE_W*RF_DEPTH_BIT-1:0]   set_rd,
    input  logic [2*ISSUE_W*RF_DEPTH_BIT-1:0] src_idx,
    output logic [2*ISSUE_W-1:0]              src_pending
);

    localparam int NREG = 1 << RF_DEPTH_BIT;
    localparam int CW   = $clog2(LOAD_LAT + 1);

    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] set_hit;

    always_comb begin
        set_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int s = 0; s < ISSUE_W; s++) begin
                if (set_en[s] && set_rd[s*RF_DEPTH_BIT +: RF_DEPTH_BIT] == RF_DEPTH_BIT'(r))
                    set_hit[r] = 1'b1;
            end
        end
    end

    // Entry 0 stays at zero from reset, so x0 sources never report pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (set_hit[r])
                    cnt[r] <= CW'(LOAD_LAT);
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    always_comb begin
        src_pending = '0;
        for (int k = 0; k < 2*ISSUE_W; k++)
            src_pending[k] = (cnt[src_idx[k*RF_DEPTH_BIT +: RF_DEPTH_BIT]] != '0);
    end

endmodule

// File: rtl/u_idu_dispatch_nway.sv
// N-wide in-order dispatcher: issues the longest legal prefix of decoded slots,
// with RAW, load-use, memory-port and WFI/exception blocking plus a HALT state.
module u_idu_dispatch_nway
    import idu_pkg::*;
#(
    parameter int ISSUE_W       = 2,
    parameter int RF_DEPTH_BIT  = 5,
    parameter int EXCEPTION_NUM = 2,
    parameter int MEM_PORTS     = 1,
    parameter int LOAD_LAT      = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [EXCEPTION_NUM-1:0]            csr_idu_core_configuration,
    input  logic                                csr_idu_resume,
    input  logic                                iex_idu_bru_flush,
    input  logic [ISSUE_W-1:0]                  instBuffer_dispatcher_inst_vld,
    input  logic [ISSUE_W-1:0]                  instBuffer_dispatcher_exception_pc_unalign,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_exception_illegal_inst,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_dmem_load,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_dmem_store,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_stall_vld,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_wfi_vld,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_rd_vld,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_rs1_vld,
    input  logic [ISSUE_W-1:0]                  idu_dispatcher_rs2_vld,
    input  logic [ISSUE_W*RF_DEPTH_BIT-1:0]     idu_dispatcher_rd,
    input  logic [ISSUE_W*RF_DEPTH_BIT-1:0]     idu_dispatcher_rs1,
    input  logic [ISSUE_W*RF_DEPTH_BIT-1:0]     idu_dispatcher_rs2,
    output logic [ISSUE_W-1:0]                  idu_iex_dispatch_vld,
    output logic [$clog2(ISSUE_W+1)-1:0]        idu_instBuffer_dispatch_cnt,
    output logic [ISSUE_W-1:0]                  idu_iex_csr_wfi_vld,
    output logic [ISSUE_W-1:0]                  idu_iex_csr_exception_vld,
    output logic [ISSUE_W*EXCEPTION_NUM-1:0]    idu_iex_csr_exceptions,
    output logic                                dispatcher_detect_exceptions_wfi,
    output logic                                idu_halted
);

    localparam int RW    = RF_DEPTH_BIT;
    localparam int CNT_W = $clog2(ISSUE_W + 1);

    disp_state_e                 state, state_nxt;
    logic [ISSUE_W-1:0]          block, disp, set_en;
    logic [2*ISSUE_W*RW-1:0]     src_idx;
    logic [2*ISSUE_W-1:0]        src_pending;
    logic                        prefix, older_special;
    int                          mem_cnt;

    // Exception classification is per slot and independent of dispatch; IEX qualifies with dispatch_vld.
    always_comb begin
        idu_iex_csr_exceptions    = '0;
        idu_iex_csr_exception_vld = '0;
        idu_iex_csr_wfi_vld       = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            idu_iex_csr_exceptions[i*EXCEPTION_NUM + EXC_PC_UNALIGN] =
                ~csr_idu_core_configuration[EXC_PC_UNALIGN] & instBuffer_dispatcher_exception_pc_unalign[i];
            idu_iex_csr_exceptions[i*EXCEPTION_NUM + EXC_ILLEGAL] =
                ~idu_iex_csr_exceptions[i*EXCEPTION_NUM + EXC_PC_UNALIGN]
                & ~csr_idu_core_configuration[EXC_ILLEGAL] & idu_dispatcher_exception_illegal_inst[i];
            idu_iex_csr_exception_vld[i] = |idu_iex_csr_exceptions[i*EXCEPTION_NUM +: EXCEPTION_NUM];
            idu_iex_csr_wfi_vld[i]       = idu_dispatcher_wfi_vld[i] & ~idu_iex_csr_exception_vld[i];
        end
    end

    always_comb begin
        src_idx = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            src_idx[(2*i)*RW   +: RW] = idu_dispatcher_rs1[i*RW +: RW];
            src_idx[(2*i+1)*RW +: RW] = idu_dispatcher_rs2[i*RW +: RW];
        end
    end

    always_comb begin
        block         = '0;
        disp          = '0;
        set_en        = '0;
        mem_cnt       = 0;
        older_special = 1'b0;
        prefix        = (state == RUN) & ~iex_idu_bru_flush;
        for (int i = 0; i < ISSUE_W; i++) begin
            mem_cnt += int'(idu_dispatcher_dmem_load[i] | idu_dispatcher_dmem_store[i]);
            block[i] = idu_dispatcher_stall_vld[i] | older_special | (mem_cnt > MEM_PORTS)
                     | (idu_dispatcher_rs1_vld[i] & src_pending[2*i])
                     | (idu_dispatcher_rs2_vld[i] & src_pending[2*i+1]);
            for (int j = 0; j < i; j++) begin
                if (idu_dispatcher_rd_vld[j] && idu_dispatcher_rd[j*RW +: RW] != '0 &&
                    ((idu_dispatcher_rs1_vld[i] && idu_dispatcher_rs1[i*RW +: RW] == idu_dispatcher_rd[j*RW +: RW]) ||
                     (idu_dispatcher_rs2_vld[i] && idu_dispatcher_rs2[i*RW +: RW] == idu_dispatcher_rd[j*RW +: RW])))
                    block[i] = 1'b1;
            end
            prefix        = prefix & instBuffer_dispatcher_inst_vld[i] & ~block[i];
            disp[i]       = prefix;
            set_en[i]     = disp[i] & idu_dispatcher_dmem_load[i] & idu_dispatcher_rd_vld[i]
                          & (idu_dispatcher_rd[i*RW +: RW] != '0);
            older_special = older_special | idu_iex_csr_exception_vld[i] | idu_iex_csr_wfi_vld[i];
        end
    end

    always_comb begin
        idu_instBuffer_dispatch_cnt = '0;
        for (int i = 0; i < ISSUE_W; i++)
            idu_instBuffer_dispatch_cnt = idu_instBuffer_dispatch_cnt + CNT_W'(disp[i]);
    end

    assign idu_iex_dispatch_vld             = disp;
    assign dispatcher_detect_exceptions_wfi = |(disp & (idu_iex_csr_exception_vld | idu_iex_csr_wfi_vld));
    assign idu_halted                       = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:  if (dispatcher_detect_exceptions_wfi)        state_nxt = HALT;
            HALT: if (iex_idu_bru_flush || csr_idu_resume)     state_nxt = RUN;
            default:                                           state_nxt = RUN;
        endcase
    end

    u_idu_load_scoreboard #(
        .ISSUE_W      (ISSUE_W),
        .RF_DEPTH_BIT (RF_DEPTH_BIT),
        .LOAD_LAT     (LOAD_LAT)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (set_en),
        .set_rd      (idu_dispatcher_rd),
        .src_idx     (src_idx),
        .src_pending (src_pending)
    );

endmodule

// File: tb/tb_u_idu_dispatch_nway.sv
// Bench for u_idu_dispatch_nway: directed scenarios plus random traffic against a
// ready-cycle reference model of the dispatch rules.
module tb_u_idu_dispatch_nway;

    localparam int W    = 4;
    localparam int RW   = 5;
    localparam int EXC  = 2;
    localparam int MP   = 2;
    localparam int LAT  = 2;
    localparam int NREG = 1 << RW;

    logic             clk = 1'b0;
    logic             rst;
    logic [EXC-1:0]   cfg;
    logic             resume, flush;
    logic [W-1:0]     vld, unalign, illegal, load, store, stall, wfi, rd_vld, rs1_vld, rs2_vld;
    logic [W*RW-1:0]  rd, rs1, rs2;
    logic [W-1:0]     disp_vld, wfi_out, exc_vld;
    logic [$clog2(W+1)-1:0] disp_cnt;
    logic [W*EXC-1:0] excs;
    logic             detect, halted;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each register records the first cycle a reader may issue.
    int           ready_at [NREG];
    int           m_cycle;
    bit           m_halted;
    logic [W-1:0]     e_disp, e_wfi, e_excv;
    logic [W*EXC-1:0] e_exc;
    int           e_cnt;
    bit           e_detect;

    always #5 clk = ~clk;

    u_idu_dispatch_nway #(
        .ISSUE_W(W), .RF_DEPTH_BIT(RW), .EXCEPTION_NUM(EXC), .MEM_PORTS(MP), .LOAD_LAT(LAT)
    ) dut (
        .clk                                        (clk),
        .rst                                        (rst),
        .csr_idu_core_configuration                 (cfg),
        .csr_idu_resume                             (resume),
        .iex_idu_bru_flush                          (flush),
        .instBuffer_dispatcher_inst_vld             (vld),
        .instBuffer_dispatcher_exception_pc_unalign (unalign),
        .idu_dispatcher_exception_illegal_inst      (illegal),
        .idu_dispatcher_dmem_load                   (load),
        .idu_dispatcher_dmem_store                  (store),
        .idu_dispatcher_stall_vld                   (stall),
        .idu_dispatcher_wfi_vld                     (wfi),
        .idu_dispatcher_rd_vld                      (rd_vld),
        .idu_dispatcher_rs1_vld                     (rs1_vld),
        .idu_dispatcher_rs2_vld                     (rs2_vld),
        .idu_dispatcher_rd                          (rd),
        .idu_dispatcher_rs1                         (rs1),
        .idu_dispatcher_rs2                         (rs2),
        .idu_iex_dispatch_vld                       (disp_vld),
        .idu_instBuffer_dispatch_cnt                (disp_cnt),
        .idu_iex_csr_wfi_vld                        (wfi_out),
        .idu_iex_csr_exception_vld                  (exc_vld),
        .idu_iex_csr_exceptions                     (excs),
        .dispatcher_detect_exceptions_wfi           (detect),
        .idu_halted                                 (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic clear_inputs();
        cfg = '0; resume = 0; flush = 0;
        vld = '0; unalign = '0; illegal = '0; load = '0; store = '0; stall = '0; wfi = '0;
        rd_vld = '0; rs1_vld = '0; rs2_vld = '0; rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic set_slot(input int s, input bit ld, input bit rdv, input int rdi,
                            input bit r1v, input int r1, input bit r2v, input int r2);
        vld[s] = 1'b1; load[s] = ld; rd_vld[s] = rdv; rs1_vld[s] = r1v; rs2_vld[s] = r2v;
        rd[s*RW +: RW] = RW'(rdi); rs1[s*RW +: RW] = RW'(r1); rs2[s*RW +: RW] = RW'(r2);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        m_halted = 0;
    endtask

    task automatic model_eval();
        int  mem;
        bit  special, ok, blk;
        int  s1, s2, dj;
        e_disp = '0; e_wfi = '0; e_excv = '0; e_exc = '0;
        for (int i = 0; i < W; i++) begin
            bit u, il;
            u  = !cfg[0] && unalign[i];
            il = !u && !cfg[1] && illegal[i];
            e_exc[i*EXC]   = u;
            e_exc[i*EXC+1] = il;
            e_excv[i] = u || il;
            e_wfi[i]  = wfi[i] && !(u || il);
        end
        ok = !m_halted && !flush;
        mem = 0; special = 0;
        for (int i = 0; i < W; i++) begin
            s1 = int'(rs1[i*RW +: RW]);
            s2 = int'(rs2[i*RW +: RW]);
            if (load[i] || store[i]) mem++;
            blk = !vld[i] || stall[i] || special || (mem > MP);
            if (rs1_vld[i] && m_cycle < ready_at[s1]) blk = 1;
            if (rs2_vld[i] && m_cycle < ready_at[s2]) blk = 1;
            for (int j = 0; j < i; j++) begin
                dj = int'(rd[j*RW +: RW]);
                if (rd_vld[j] && dj != 0 && ((rs1_vld[i] && s1 == dj) || (rs2_vld[i] && s2 == dj)))
                    blk = 1;
            end
            if (ok && !blk) e_disp[i] = 1'b1;
            else ok = 0;
            if (e_excv[i] || wfi[i]) special = 1;
        end
        e_cnt = 0;
        e_detect = 0;
        for (int i = 0; i < W; i++) begin
            if (e_disp[i]) e_cnt++;
            if (e_disp[i] && (e_excv[i] || e_wfi[i])) e_detect = 1;
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < W; i++)
            if (e_disp[i] && load[i] && rd_vld[i] && rd[i*RW +: RW] != '0)
                ready_at[int'(rd[i*RW +: RW])] = m_cycle + LAT + 1;
        if (!m_halted && e_detect)              m_halted = 1;
        else if (m_halted && (flush || resume)) m_halted = 0;
        m_cycle++;
    endtask

    // Sample on the falling edge and compare every output with the model.
    task automatic settle();
        @(negedge clk);
        model_eval();
        check("dispatch_vld", 32'(disp_vld), 32'(e_disp));
        check("dispatch_cnt", 32'(disp_cnt), 32'(e_cnt));
        check("wfi_vld",      32'(wfi_out),  32'(e_wfi));
        check("exc_vld",      32'(exc_vld),  32'(e_excv));
        check("exceptions",   32'(excs),     32'(e_exc));
        check("detect",       32'(detect),   32'(e_detect));
        check("halted",       32'(halted),   32'(m_halted));
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("async_rst_halted", 32'(halted), 32'(0));
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        clear_inputs();
        for (int i = 0; i < W; i++) begin
            vld[i]     = ($urandom_range(0, 7) != 0);
            load[i]    = ($urandom_range(0, 3) == 0);
            store[i]   = !load[i] && ($urandom_range(0, 7) == 0);
            stall[i]   = ($urandom_range(0, 15) == 0);
            wfi[i]     = ($urandom_range(0, 31) == 0);
            illegal[i] = ($urandom_range(0, 31) == 0);
            unalign[i] = ($urandom_range(0, 47) == 0);
            rd_vld[i]  = 1'($urandom_range(0, 1));
            rs1_vld[i] = 1'($urandom_range(0, 1));
            rs2_vld[i] = 1'($urandom_range(0, 1));
            rd[i*RW +: RW]  = RW'($urandom_range(0, 7));
            rs1[i*RW +: RW] = RW'($urandom_range(0, 7));
            rs2[i*RW +: RW] = RW'($urandom_range(0, 7));
        end
        flush  = ($urandom_range(0, 15) == 0);
        resume = ($urandom_range(0, 5) == 0);
        cfg    = ($urandom_range(0, 3) == 0) ? EXC'($urandom_range(0, 3)) : '0;
    endtask

    initial begin
        int got;
        rst = 1'b1;
        clear_inputs();
        m_cycle = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset.
        settle();
        check("idle_disp", 32'(disp_vld), 32'(0));
        check("idle_halted", 32'(halted), 32'(0));
        tick();

        // RAW inside the issue group.
        clear_inputs();
        set_slot(0, 0, 1, 5, 0, 0, 0, 0);
        set_slot(1, 0, 1, 6, 1, 5, 0, 0);
        settle();
        check("raw_disp", 32'(disp_vld), 32'(4'b0001));
        check("raw_cnt", 32'(disp_cnt), 32'(1));
        tick();
        clear_inputs();
        set_slot(0, 0, 1, 6, 1, 5, 0, 0);
        settle();
        check("raw_next", 32'(disp_vld), 32'(4'b0001));
        tick();

        // Memory-port limit with four loads.
        clear_inputs();
        for (int i = 0; i < W; i++) set_slot(i, 1, 1, i + 1, 0, 0, 0, 0);
        settle();
        check("mem_cnt_a", 32'(disp_cnt), 32'(2));
        tick();
        clear_inputs();
        set_slot(0, 1, 1, 3, 0, 0, 0, 0);
        set_slot(1, 1, 1, 4, 0, 0, 0, 0);
        settle();
        check("mem_cnt_b", 32'(disp_cnt), 32'(2));
        tick();

        // Load-use distance on x7.
        clear_inputs();
        set_slot(0, 1, 1, 7, 0, 0, 0, 0);
        settle();
        tick();
        clear_inputs();
        set_slot(0, 0, 1, 8, 1, 7, 0, 0);
        got = -1;
        for (int k = 1; k <= 8 && got < 0; k++) begin
            settle();
            if (disp_vld[0]) got = k;
            tick();
        end
        check("load_use_gap", 32'(got), 32'(LAT + 1));

        // A load to x0 blocks nothing.
        clear_inputs();
        set_slot(0, 1, 1, 0, 0, 0, 0, 0);
        settle();
        tick();
        clear_inputs();
        set_slot(0, 0, 1, 9, 1, 0, 1, 0);
        settle();
        check("x0_reader", 32'(disp_vld), 32'(4'b0001));
        tick();

        // Exception in slot 1 halts until resume.
        clear_inputs();
        for (int i = 0; i < W; i++) set_slot(i, 0, 1, 10 + i, 0, 0, 0, 0);
        illegal[1] = 1'b1; unalign[1] = 1'b1;
        settle();
        check("exc_slot1", 32'(excs[3:2]), 32'(2'b01));
        check("exc_detect", 32'(detect), 32'(1));
        check("exc_disp", 32'(disp_vld), 32'(4'b0011));
        tick();
        for (int k = 0; k < 3; k++) begin
            settle();
            check("halt_hold", 32'(halted), 32'(1));
            tick();
        end
        resume = 1'b1;
        settle();
        tick();
        clear_inputs();
        settle();
        check("resumed", 32'(halted), 32'(0));
        tick();

        // WFI plus illegal with flush in the same cycle.
        clear_inputs();
        set_slot(0, 0, 0, 0, 0, 0, 0, 0);
        wfi[0] = 1'b1; illegal[0] = 1'b1; flush = 1'b1;
        settle();
        check("wfi_masked", 32'(wfi_out[0]), 32'(0));
        check("wfi_exc", 32'(exc_vld[0]), 32'(1));
        check("flush_disp", 32'(disp_vld), 32'(0));
        tick();
        clear_inputs();
        settle();
        check("flush_no_halt", 32'(halted), 32'(0));
        tick();

        // Reset while halted with a load pending.
        clear_inputs();
        set_slot(0, 1, 1, 12, 0, 0, 0, 0);
        set_slot(1, 0, 0, 0, 0, 0, 0, 0);
        wfi[1] = 1'b1;
        settle();
        tick();
        clear_inputs();
        set_slot(0, 0, 1, 13, 1, 12, 0, 0);
        settle();
        check("pre_rst_halted", 32'(halted), 32'(1));
        apply_reset();
        settle();
        check("post_rst_reader", 32'(disp_vld), 32'(4'b0001));
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            settle();
            tick();
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
